// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: video fetch, CPU access, RAM port and stall counter.
// slave = arbiter side, master = system side (video timing, CPU, RAM).
interface vram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              ce_vid;
    logic              hblank;
    logic              vblank;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    logic [15:0]       stall_count;

    modport slave (
        input  ce_vid, hblank, vblank, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_q,
        output vid_data, vid_valid, cpu_rdata, cpu_ready,
        output ram_addr, ram_we, ram_wdata, stall_count
    );

    modport master (
        output ce_vid, hblank, vblank, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_q,
        input  vid_data, vid_valid, cpu_rdata, cpu_ready,
        input  ram_addr, ram_we, ram_wdata, stall_count
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between scanout fetches (absolute priority) and a CPU port.
// Define VRAM_ARB_VBLANK_ONLY_EN to restrict CPU accesses to vertical blank.
module vram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_pend_q, vid_pend_d;
    logic [15:0]       stall_q, stall_d;

    logic              video_slot;
    logic              cpu_slot;
    logic              cpu_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    assign video_slot = bus.ce_vid & ~bus.hblank & ~bus.vblank;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
    assign cpu_slot = ~video_slot & bus.vblank;
`else
    assign cpu_slot = ~video_slot;
`endif

    assign cpu_ready = reset | (state_q == DONE) | ~bus.cpu_req;

    // CPU access FSM; the RAM port defaults to the scanout address.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ram_addr    = bus.vid_addr;
        ram_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    state_d = GRANT;
                    addr_d  = bus.cpu_addr;
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                end
            end
            GRANT: begin
                if (cpu_slot) begin
                    ram_addr = addr_q;
                    if (we_q) begin
                        ram_we  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                cpu_rdata_d = bus.ram_q;
                state_d     = DONE;
            end
            DONE: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Video capture pipeline: address out in the slot, RAM data one cycle later.
    always_comb begin
        vid_pend_d  = video_slot;
        vid_valid_d = vid_pend_q;
        vid_data_d  = vid_pend_q ? bus.ram_q : vid_data_q;
        stall_d     = stall_q;
        if (!cpu_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_pend_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            vid_pend_q  <= vid_pend_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.vid_data    = vid_data_q;
    assign bus.vid_valid   = vid_valid_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ready   = cpu_ready;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_we      = ram_we;
    assign bus.ram_wdata   = wdata_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: random raster/CPU traffic against a memory-level model,
// plus directed write/read, video collision, reset abort and stall saturation scenarios.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NCELL = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Single-port synchronous RAM, one-cycle read latency, preset with a known pattern.
    logic [DW-1:0] mem [0:NCELL-1];
    bit            wflag [0:NCELL-1];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 11);
    endfunction

    function automatic logic [DW-1:0] ram_peek(input int a);
        return wflag[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]   <= bus.ram_wdata;
            wflag[bus.ram_addr] <= 1'b1;
        end
        bus.ram_q <= ram_peek(int'(bus.ram_addr));
    end

    typedef struct {
        bit            we;
        int            addr;
        logic [DW-1:0] data;
        int            req_cyc;
        int            exp_lat;
    } cpu_txn_t;

    cpu_txn_t      cpu_q [$];
    logic [DW-1:0] vid_q [$];
    logic [DW-1:0] ref_mem [0:NCELL-1];
    bit            cslot_hist [0:131071];

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     we_cnt = 0;
    longint model_stall = 0;
    int     vmode = 1;
    bit     allow_new = 0;
    bit     rst_next = 1;
    bit     ready_seen = 0;
    bit     pend = 0;
    int     pend_addr = 0;
    int     gap = 0;
    int     req_cyc = 0;
    bit     quiet = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs with scoreboard entries at the falling edge.
    cpu_txn_t mon_t;
    int       mon_g;
    int       mon_e;
    always @(negedge clk) begin
        if (reset) begin
            chk("ready_in_reset", longint'(bus.cpu_ready), 1);
            chk("we_in_reset", longint'(bus.ram_we), 0);
            model_stall = 0;
        end else begin
            if (bus.ram_we) we_cnt++;
            if (bus.vid_valid) begin
                if (vid_q.size() == 0) begin
                    chk("vid_unexpected", 1, 0);
                end else begin
                    logic [DW-1:0] ev;
                    ev = vid_q.pop_front();
                    chk("vid_data", longint'(bus.vid_data), longint'(ev));
                    if (!quiet) $display("vid  cyc=%0d data=%02h", cyc, bus.vid_data);
                end
            end
            if (bus.cpu_req && bus.cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_unexpected", 1, 0);
                end else begin
                    mon_t = cpu_q.pop_front();
                    mon_g = -1;
                    for (int k = mon_t.req_cyc + 1; k <= cyc; k++) begin
                        if (cslot_hist[k]) begin
                            mon_g = k;
                            break;
                        end
                    end
                    mon_e = (mon_g < 0) ? -1 : mon_g + (mon_t.we ? 1 : 2);
                    chk("cpu_latency", longint'(cyc - mon_t.req_cyc), longint'(mon_e - mon_t.req_cyc));
                    if (!mon_t.we) chk("cpu_rdata", longint'(bus.cpu_rdata), longint'(mon_t.data));
                    if (mon_t.exp_lat > 0) chk("cpu_lat_fixed", longint'(cyc - mon_t.req_cyc), longint'(mon_t.exp_lat));
                    model_stall += (mon_e >= 0) ? (mon_e - mon_t.req_cyc) : (cyc - mon_t.req_cyc);
                    $display("cpu  %s addr=%03h data=%02h lat=%0d", mon_t.we ? "wr" : "rd",
                             mon_t.addr, mon_t.we ? mon_t.data : bus.cpu_rdata, cyc - mon_t.req_cyc);
                end
            end else if (!bus.cpu_req) begin
                chk("stall_count", longint'(bus.stall_count), (model_stall > 65535) ? 65535 : model_stall);
            end
        end
    end

    task automatic issue(input bit we, input int addr, input logic [DW-1:0] data, input int exp_lat);
        cpu_txn_t t;
        t.we = we;
        t.addr = addr;
        t.req_cyc = cyc;
        t.exp_lat = exp_lat;
        if (we) begin
            ref_mem[addr] = data;
            t.data = data;
            pend = 1;
            pend_addr = addr;
        end else begin
            t.data = ref_mem[addr];
        end
        cpu_q.push_back(t);
        req_cyc = cyc;
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = AW'(addr);
        bus.cpu_wdata = data;
    endtask

    task automatic gen_cpu();
        if (bus.cpu_req) begin
            if (ready_seen) begin
                bus.cpu_req = 1'b0;
                pend = 0;
                gap = $urandom_range(0, 3);
            end else if (cyc - req_cyc > 70000) begin
                chk("cpu_timeout", 1, 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            // Request-side inputs wander while the access is in flight.
            bus.cpu_we = 1'($urandom_range(0, 1));
            bus.cpu_addr = AW'($urandom);
            bus.cpu_wdata = DW'($urandom);
        end else if (gap > 0) begin
            gap--;
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 31), DW'($urandom), 0);
        end
    endtask

    task automatic gen_video();
        bit ce, hb, vb, vs;
        int t, a;
        ce = (cyc % 4 == 0);
        hb = 0;
        vb = 0;
        t = cyc / 4;
        case (vmode)
            0: begin
                hb = ((t % 16) >= 12);
                vb = (((t / 16) % 16) >= 12);
            end
            1: vb = 1;
            2: ce = 1;
            default: ;
        endcase
        do begin
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NCELL - 1);
        end while (pend && a == pend_addr);
        bus.ce_vid = ce;
        bus.hblank = hb;
        bus.vblank = vb;
        bus.vid_addr = AW'(a);
        vs = ce & ~hb & ~vb;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
        cslot_hist[cyc] = ~vs & vb;
`else
        cslot_hist[cyc] = ~vs;
`endif
        if (vs && !reset) vid_q.push_back(ref_mem[a]);
    endtask

    task automatic tick();
        @(negedge clk);
        ready_seen = bus.cpu_req && bus.cpu_ready && !reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_next && !reset) begin
            vid_q.delete();
            cpu_q.delete();
        end
        reset = rst_next;
        gen_cpu();
        gen_video();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.cpu_req && n < 80000) begin
            tick();
            n++;
        end
    endtask

    int we_before;

    initial begin
        for (int i = 0; i < NCELL; i++) ref_mem[i] = init_val(i);
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.ce_vid = 1'b0;
        bus.hblank = 1'b0;
        bus.vblank = 1'b1;
        bus.vid_addr = '0;

        repeat (3) tick();
        rst_next = 0;
        tick();
        chk("rst_vid_data", longint'(bus.vid_data), 0);
        chk("rst_vid_valid", longint'(bus.vid_valid), 0);
        chk("rst_cpu_rdata", longint'(bus.cpu_rdata), 0);
        chk("rst_stall_count", longint'(bus.stall_count), 0);

        // Idle bus in vblank: write then read back the same cell.
        vmode = 1;
        tick();
        we_before = we_cnt;
        issue(1, 'h123, 8'h5A, 2);
        wait_idle();
        chk("write_we_pulses", longint'(we_cnt - we_before), 1);
        chk("ram_cell_0x123", longint'(ram_peek('h123)), 'h5A);
        tick();
        issue(0, 'h123, 8'h00, 3);
        wait_idle();

`ifndef VRAM_ARB_VBLANK_ONLY_EN
        // Active display with the video slot landing on the GRANT cycle.
        vmode = 3;
        do tick(); while (cyc % 4 != 3);
        issue(0, 7, 8'h00, 4);
        wait_idle();
`endif

        // Random raster and CPU traffic.
        vmode = 0;
        allow_new = 1;
        repeat (3000) tick();
        allow_new = 0;
        wait_idle();
        repeat (4) tick();

        // Reset while a write is stalled in GRANT behind continuous video slots.
        vmode = 2;
        tick();
        we_before = we_cnt;
        req_cyc = cyc;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = AW'('h2AA);
        bus.cpu_wdata = 8'hC3;
        repeat (3) tick();
        rst_next = 1;
        tick();
        tick();
        bus.cpu_req = 1'b0;
        rst_next = 0;
        vmode = 1;
        tick();
        tick();
        chk("reset_abort_ram", longint'(ram_peek('h2AA)), longint'(ref_mem['h2AA]));
        chk("reset_abort_we", longint'(we_cnt - we_before), 0);
        issue(0, 'h2AA, 8'h00, 3);
        wait_idle();

        // Long stall: stall_count must saturate rather than wrap.
        vmode = 2;
        quiet = 1;
        tick();
        issue(0, 5, 8'h00, 0);
        repeat (65600) tick();
        vmode = 1;
        wait_idle();
        quiet = 0;
        tick();
        chk("stall_saturated", longint'(bus.stall_count), 'hFFFF);
        repeat (4) tick();
        chk("vid_queue_drained", longint'(vid_q.size()), 0);
        chk("cpu_queue_drained", longint'(cpu_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
